output_limit_fifo_param: RTL and testbench

Parametrised single-clock output FIFO with an output-limit mode. It replaces the fixed 16-bit limit FIFO in the high-speed output path, sitting after the clock-crossing stage and feeding the USB output logic. It adds configurable data width, depth, limit width and almost-full margin, a fill-level output, and a defined reset. In limit mode the reader sees only a registered snapshot of the stored words.

---
 rtl/output_limit_fifo_param.sv | 123 ++++++++++++
 tb/tb_output_limit_fifo_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_limit_fifo_param.sv
// First-word-fall-through FIFO with an optional output limit. In limit mode the reader may pop at most
// the registered snapshot of the fill level. Writes are dropped when full and reads are ignored when empty.
module output_limit_fifo_param #(
  parameter int WIDTH     = 16,
  parameter int ADDR_MSB  = 13,
  parameter int LIMIT_W   = 16,
  parameter int AF_MARGIN = 16
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    din,
  input  logic                wr_en,
  output logic                full,
  output logic                almost_full,
  output logic [WIDTH-1:0]    dout,
  input  logic                rd_en,
  output logic                empty,
  output logic [ADDR_MSB+1:0] count,
  input  logic                mode_limit,
  input  logic                reg_output_limit,
  output logic [LIMIT_W-1:0]  output_limit,
  output logic                output_limit_not_done
);
  localparam int AW    = ADDR_MSB + 1;
  localparam int PW    = ADDR_MSB + 2;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = (PW > LIMIT_W) ? PW : LIMIT_W;
  localparam logic [PW-1:0]      DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0]      AF_LEVEL  = PW'(DEPTH - AF_MARGIN);
  localparam logic [LIMIT_W-1:0] LIMIT_MAX = '1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_vis_q, count_q, count_d;
  logic               full_q, full_d, af_q, af_d;
  logic [WIDTH-1:0]   dout_q;
  logic               dout_vld_q, dout_vld_d, stage_load;
  logic [AW-1:0]      stage_addr;
  logic [LIMIT_W-1:0] remaining_q, remaining_d, output_limit_q, output_limit_d, snap;
  logic               not_done_q;
  logic               wr_acc, rd_acc, reg_acc;
  logic [SW-1:0]      cnt_w;

  assign empty   = ~dout_vld_q | (mode_limit & (remaining_q == '0));
  assign wr_acc  = wr_en & ~full_q;
  assign rd_acc  = rd_en & ~empty;
  assign reg_acc = reg_output_limit & mode_limit & (remaining_q == '0);

  assign wr_ptr_d = wr_ptr_q + PW'(wr_acc);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_acc);
  assign count_d  = wr_ptr_d - rd_ptr_d;
  assign full_d   = (count_d == DEPTH_P);
  assign af_d     = (count_d >= AF_LEVEL);

  // A pop refills from the live write pointer; refilling an idle stage waits on the one-edge-old pointer.
  always_comb begin
    stage_load = 1'b0;
    stage_addr = rd_ptr_q[AW-1:0];
    dout_vld_d = dout_vld_q;
    if (rd_acc) begin
      stage_addr = rd_ptr_q[AW-1:0] + AW'(1);
      stage_load = ((rd_ptr_q + PW'(1)) != wr_ptr_q);
      dout_vld_d = stage_load;
    end else if (!dout_vld_q) begin
      stage_load = (rd_ptr_q != wr_vis_q);
      dout_vld_d = stage_load;
    end
  end

  assign cnt_w = SW'(count_q);
  assign snap  = (cnt_w > SW'(LIMIT_MAX)) ? LIMIT_MAX : LIMIT_W'(cnt_w);

  always_comb begin
    remaining_d    = remaining_q;
    output_limit_d = output_limit_q;
    if (!mode_limit) begin
      remaining_d = '0;
    end else if (reg_acc) begin
      remaining_d    = snap;
      output_limit_d = snap;
    end else if (rd_acc) begin
      remaining_d = remaining_q - LIMIT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_vis_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      af_q           <= 1'b0;
      dout_q         <= '0;
      dout_vld_q     <= 1'b0;
      remaining_q    <= '0;
      output_limit_q <= '0;
      not_done_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_vis_q       <= wr_ptr_q;
      count_q        <= count_d;
      full_q         <= full_d;
      af_q           <= af_d;
      dout_vld_q     <= dout_vld_d;
      remaining_q    <= remaining_d;
      output_limit_q <= output_limit_d;
      not_done_q     <= (remaining_d != '0);
      if (stage_load) dout_q <= mem[stage_addr];
    end
  end

  assign full                  = full_q;
  assign almost_full           = af_q;
  assign count                 = count_q;
  assign dout                  = dout_q;
  assign output_limit          = output_limit_q;
  assign output_limit_not_done = not_done_q;
endmodule

// File: tb/tb_output_limit_fifo_param.sv
// Bench for output_limit_fifo_param: directed steps plus random traffic against a queue-based model.
module tb_output_limit_fifo_param;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 4;
  localparam int LMAX      = 65535;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n;
  logic [15:0] din, dout;
  logic        wr_en, rd_en, full, almost_full, empty, mode_limit, reg_output_limit, output_limit_not_done;
  logic [4:0]  count;
  logic [15:0] output_limit;

  logic [15:0] s_din, s_dout;
  logic        s_wr, s_rd, s_full, s_af, s_empty, s_mode, s_reg, s_nd;
  logic [4:0]  s_count;
  logic [2:0]  s_olim;

  int checks = 0;
  int errors = 0;

  output_limit_fifo_param #(.WIDTH(16), .ADDR_MSB(3), .LIMIT_W(16), .AF_MARGIN(AF_MARGIN)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full), .almost_full(almost_full),
    .dout(dout), .rd_en(rd_en), .empty(empty), .count(count), .mode_limit(mode_limit),
    .reg_output_limit(reg_output_limit), .output_limit(output_limit),
    .output_limit_not_done(output_limit_not_done)
  );

  output_limit_fifo_param #(.WIDTH(16), .ADDR_MSB(3), .LIMIT_W(3), .AF_MARGIN(AF_MARGIN)) u_sat (
    .CLK(CLK), .rst_n(rst_n), .din(s_din), .wr_en(s_wr), .full(s_full), .almost_full(s_af),
    .dout(s_dout), .rd_en(s_rd), .empty(s_empty), .count(s_count), .mode_limit(s_mode),
    .reg_output_limit(s_reg), .output_limit(s_olim), .output_limit_not_done(s_nd)
  );

  // Reference model: stored words with the edge they were written on, staged flag, limit state.
  typedef struct {
    logic [15:0] d;
    int          we;
  } ent_t;
  ent_t mq[$];
  bit   m_stg;
  int   m_rem, m_olim, m_edge;

  logic [15:0] wdat [DEPTH];
  logic [15:0] sdat [12];
  bit          mode_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_empty();
    return !m_stg || (mode_limit && m_rem == 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stg  = 1'b0;
    m_rem  = 0;
    m_olim = 0;
  endtask

  task automatic model_edge();
    int szb  = mq.size();
    bit pop  = rd_en && !m_empty();
    bit push = wr_en && (szb < DEPTH);
    bit rg   = reg_output_limit && mode_limit && (m_rem == 0);
    int snap = (szb > LMAX) ? LMAX : szb;
    m_edge++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{din, m_edge});
    if (pop) m_stg = (szb > 1);
    else if (!m_stg) m_stg = (mq.size() > 0) && (mq[0].we <= m_edge - 2);
    if (!mode_limit) m_rem = 0;
    else if (rg) m_rem = snap;
    else if (pop) m_rem--;
    if (rg) m_olim = snap;
  endtask

  task automatic compare();
    bit e = m_empty();
    chk("empty", 32'(empty), 32'(e));
    if (!e) chk("dout", 32'(dout), 32'(mq[0].d));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - AF_MARGIN));
    chk("output_limit", 32'(output_limit), 32'(m_olim));
    chk("not_done", 32'(output_limit_not_done), 32'(m_rem != 0));
  endtask

  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic m, input logic g);
    wr_en = w; din = d; rd_en = r; mode_limit = m; reg_output_limit = g;
    @(posedge CLK);
    model_edge();
    #1;
    compare();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_olim"}, 32'(output_limit), 32'd0);
    chk({tag, "_nd"}, 32'(output_limit_not_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; wr_en = 0; rd_en = 0; mode_limit = 0; reg_output_limit = 0;
    s_din = '0; s_wr = 0; s_rd = 0; s_mode = 0; s_reg = 0;
    m_edge = 0;
    model_reset();
    #12;
    chk_reset("por");
    @(negedge CLK);
    rst_n = 1'b1;

    // Single word: written at edge 1, visible after edge 3.
    step(1, 16'h1234, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("first_word_not_yet", 32'(empty), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("first_word_empty", 32'(empty), 32'd0);
    chk("first_word_dout", 32'(dout), 32'h1234);
    chk("first_word_count", 32'(count), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("first_word_drained", 32'(empty), 32'd1);

    // Fill to full, drop one, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      wdat[i] = 16'($urandom);
      step(1, wdat[i], 0, 0, 0);
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 12));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    step(1, 16'hDEAD, 0, 0, 0);
    chk("drop_count", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_order", 32'(dout), 32'(wdat[i]));
      step(0, 0, 1, 0, 0);
    end
    chk("fill_drained_empty", 32'(empty), 32'd1);
    chk("fill_drained_count", 32'(count), 32'd0);

    // Limit mode.
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("lim_gated_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 1, 1);
    chk("lim_olim10", 32'(output_limit), 32'd10);
    chk("lim_nd_set", 32'(output_limit_not_done), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 0);
    chk("lim_nd_clear", 32'(output_limit_not_done), 32'd0);
    chk("lim_done_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("lim_wait_reg_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 1, 1);
    chk("lim_olim3", 32'(output_limit), 32'd3);
    step(1, 16'($urandom), 0, 1, 0);
    step(1, 16'($urandom), 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("lim_reg_ignored", 32'(output_limit), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    chk("lim_after3_empty", 32'(empty), 32'd1);
    chk("lim_after3_count", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1 == 0);
    step(1, 16'($urandom), 0, 1, 1);
    chk("lim_reg_with_write", 32'(output_limit), 32'd5);
    chk("lim_reg_with_write_count", 32'(count), 32'd6);
    step(0, 0, 0, 0, 0);
    chk("mode_off_nd", 32'(output_limit_not_done), 32'd0);
    chk("mode_off_empty", 32'(empty), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    chk("mode_off_drained", 32'(empty), 32'd1);

    // Random traffic, including mode flips and limit requests.
    mode_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) mode_r = !mode_r;
      step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 5, mode_r,
           $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset mid-burst, asserted off the clock edge.
    for (int i = 0; i < 6; i++) step(1, 16'($urandom), 0, 0, 0);
    step(1, 16'($urandom), 1, 0, 0);
    #3;
    rst_n = 1'b0;
    wr_en = 0; rd_en = 0; mode_limit = 0; reg_output_limit = 0;
    #1;
    chk_reset("mid_rst");
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;

    // Wrap-around with concurrent read and write.
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1, 16'($urandom), 1, 0, 0);
      chk("wrap_count", 32'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    chk("wrap_drained", 32'(empty), 32'd1);

    // Snapshot saturation with a 3-bit limit.
    for (int i = 0; i < 12; i++) begin
      sdat[i] = 16'($urandom);
      s_wr = 1; s_din = sdat[i];
      @(posedge CLK);
      #1;
    end
    s_wr = 0; s_mode = 1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("sat_count12", 32'(s_count), 32'd12);
    s_reg = 1;
    @(posedge CLK); #1;
    s_reg = 0;
    chk("sat_olim", 32'(s_olim), 32'd7);
    chk("sat_nd", 32'(s_nd), 32'd1);
    for (int i = 0; i < 7; i++) begin
      chk("sat_order", 32'(s_dout), 32'(sdat[i]));
      chk("sat_readable", 32'(s_empty), 32'd0);
      s_rd = 1;
      @(posedge CLK); #1;
    end
    s_rd = 0;
    chk("sat_empty", 32'(s_empty), 32'd1);
    chk("sat_count5", 32'(s_count), 32'd5);
    chk("sat_nd_clear", 32'(s_nd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
